// File: rtl/mc_cu.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/mem/write-back
// over a shared memory port and raises sticky trap causes for bad encodings or bus stalls.
module mc_cu #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       branch,
    output logic       jump,
    output logic [1:0] mem_out_sel,
    output logic [2:0] mem_read,
    output logic [1:0] mem_write,
    output logic       reg_write,
    output logic [2:0] state,
    output logic       illegal_instr,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic [1:0] mem_out_sel;
        logic       reg_write;
        logic       jump;
        logic       branch;
        logic [2:0] mem_read;
        logic [1:0] mem_write;
    } flags_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam bit             TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_q;
    state_t           state_next;
    flags_t           flags_q;
    flags_t           dec;
    logic             dec_illegal;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             set_illegal;
    logic             set_bus_err;
    logic             is_load;
    logic             is_store;
    logic             is_cond_branch;

    // Memory handshake: a request (imem_req/dmem_req) is held every cycle the
    // FSM sits in FETCH/MEM; the cycle mem_ready=1 completes the transfer and the
    // FSM leaves that state on the following edge. There is no back-pressure on
    // the control side; mem_ready is the sole completion signal.

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op = 2'b00; dec.alu_src = 1'b1; dec.mem_out_sel = 2'b11; dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op = 2'b10; dec.alu_src = 1'b1; dec.mem_out_sel = 2'b00; dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op = 2'b10; dec.alu_src = 1'b1; dec.mem_out_sel = 2'b10; dec.reg_write = 1'b1;
                dec.jump   = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op = 2'b10; dec.alu_src = 1'b1; dec.mem_out_sel = 2'b10; dec.reg_write = 1'b1;
                dec.jump   = 1'b1;  dec.branch  = 1'b1;
            end
            OPC_OPIMM: begin
                dec.alu_op = 2'b11; dec.alu_src = 1'b1; dec.mem_out_sel = 2'b00; dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                dec.alu_op = 2'b11; dec.alu_src = 1'b0; dec.mem_out_sel = 2'b00; dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_op = 2'b10; dec.alu_src = 1'b1; dec.mem_out_sel = 2'b01; dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_read = 3'b100;
                    3'b001:  dec.mem_read = 3'b010;
                    3'b010:  dec.mem_read = 3'b001;
                    3'b100:  dec.mem_read = 3'b101;
                    3'b101:  dec.mem_read = 3'b011;
                    default: dec_illegal  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.alu_op = 2'b10; dec.alu_src = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_write = 2'b11;
                    3'b001:  dec.mem_write = 2'b10;
                    3'b010:  dec.mem_write = 2'b01;
                    default: dec_illegal   = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec.alu_op = 2'b01; dec.alu_src = 1'b0; dec.branch = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                dec = '0;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign is_load        = |flags_q.mem_read;
    assign is_store       = |flags_q.mem_write;
    assign is_cond_branch = flags_q.branch & ~flags_q.jump;
    // The MEM_TIMEOUT-th waiting cycle is the one where the counter reads MEM_TIMEOUT-1.
    assign timeout_hit    = TO_EN && (wait_cnt == TO_LAST) && !mem_ready;

    always_comb begin
        state_next  = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        alu_op      = 2'b00;
        alu_src     = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        mem_out_sel = 2'b00;
        mem_read    = 3'b000;
        mem_write   = 2'b00;
        reg_write   = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state_q)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    state_next  = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_op  = flags_q.alu_op;
                alu_src = flags_q.alu_src;
                branch  = flags_q.branch;
                jump    = flags_q.jump;
                if (is_cond_branch) begin
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                alu_op    = flags_q.alu_op;
                alu_src   = flags_q.alu_src;
                branch    = flags_q.branch;
                jump      = flags_q.jump;
                mem_read  = flags_q.mem_read;
                mem_write = flags_q.mem_write;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_WB: begin
                alu_op      = flags_q.alu_op;
                alu_src     = flags_q.alu_src;
                branch      = flags_q.branch;
                jump        = flags_q.jump;
                mem_out_sel = flags_q.mem_out_sel;
                reg_write   = flags_q.reg_write;
                pc_write    = 1'b1;
                state_next  = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (state_q == S_DECODE) begin
            flags_q <= dec_illegal ? '0 : dec;
        end
    end

    // Counter restarts whenever a FETCH or MEM phase begins and saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_next == S_FETCH || state_next == S_MEM) && state_next != state_q) begin
            wait_cnt <= '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && !(&wait_cnt)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_instr <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            if (set_illegal) illegal_instr <= 1'b1;
            if (set_bus_err) bus_err       <= 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: per-cycle expected output vectors come from an instruction-level
// model of the control sequence and are compared at the falling edge.
module tb_mc_cu;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       mem_ready = 1'b0;

    logic       imem_req, dmem_req, ir_write, pc_write, alu_src, branch, jump, reg_write;
    logic       illegal_instr, bus_err;
    logic [1:0] alu_op, mem_out_sel, mem_write;
    logic [2:0] mem_read, state;

    logic       imem_req_z, dmem_req_z, ir_write_z, pc_write_z, alu_src_z, branch_z, jump_z, reg_write_z;
    logic       illegal_instr_z, bus_err_z;
    logic [1:0] alu_op_z, mem_out_sel_z, mem_write_z;
    logic [2:0] mem_read_z, state_z;

    logic [21:0] obs;
    logic [22:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_tag  = "init";

    typedef struct packed {
        logic       legal;
        logic [1:0] kind;     // 0 write-back path, 1 load, 2 store, 3 conditional branch
        logic [1:0] alu_op;
        logic       alu_src;
        logic       jump;
        logic       branch;
        logic [1:0] mos;
        logic       rw;
        logic [2:0] mr;
        logic [1:0] mw;
    } ref_t;

    mc_cu #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
        .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .jump(jump),
        .mem_out_sel(mem_out_sel), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .state(state), .illegal_instr(illegal_instr), .bus_err(bus_err)
    );

    mc_cu dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .imem_req(imem_req_z), .dmem_req(dmem_req_z), .ir_write(ir_write_z), .pc_write(pc_write_z),
        .alu_op(alu_op_z), .alu_src(alu_src_z), .branch(branch_z), .jump(jump_z),
        .mem_out_sel(mem_out_sel_z), .mem_read(mem_read_z), .mem_write(mem_write_z),
        .reg_write(reg_write_z), .state(state_z), .illegal_instr(illegal_instr_z), .bus_err(bus_err_z)
    );

    // Clock / reset
    always #5 clk = ~clk;

    assign obs = {state, imem_req, dmem_req, ir_write, pc_write, alu_op, alu_src, jump, branch,
                  mem_out_sel, mem_read, mem_write, reg_write, illegal_instr, bus_err};

    function automatic ref_t ref_decode(input logic [6:0] op, input logic [2:0] f3);
        ref_t r;
        r       = '0;
        r.legal = 1'b1;
        case (op)
            7'b0110111: begin r.alu_op = 2'b00; r.alu_src = 1; r.mos = 2'b11; r.rw = 1; end
            7'b0010111: begin r.alu_op = 2'b10; r.alu_src = 1; r.mos = 2'b00; r.rw = 1; end
            7'b1101111: begin r.alu_op = 2'b10; r.alu_src = 1; r.mos = 2'b10; r.rw = 1; r.jump = 1; end
            7'b1100111: begin r.alu_op = 2'b10; r.alu_src = 1; r.mos = 2'b10; r.rw = 1; r.jump = 1; r.branch = 1; end
            7'b0010011: begin r.alu_op = 2'b11; r.alu_src = 1; r.mos = 2'b00; r.rw = 1; end
            7'b0110011: begin r.alu_op = 2'b11; r.alu_src = 0; r.mos = 2'b00; r.rw = 1; end
            7'b0000011: begin
                r.kind = 2'd1; r.alu_op = 2'b10; r.alu_src = 1; r.mos = 2'b01; r.rw = 1;
                case (f3)
                    3'd0: r.mr = 3'b100;
                    3'd1: r.mr = 3'b010;
                    3'd2: r.mr = 3'b001;
                    3'd4: r.mr = 3'b101;
                    3'd5: r.mr = 3'b011;
                    default: r.legal = 0;
                endcase
            end
            7'b0100011: begin
                r.kind = 2'd2; r.alu_op = 2'b10; r.alu_src = 1;
                case (f3)
                    3'd0: r.mw = 2'b11;
                    3'd1: r.mw = 2'b10;
                    3'd2: r.mw = 2'b01;
                    default: r.legal = 0;
                endcase
            end
            7'b1100011: begin
                r.kind = 2'd3; r.alu_op = 2'b01; r.alu_src = 0; r.branch = 1;
                r.legal = !(f3 == 3'd2 || f3 == 3'd3);
            end
            7'b0001111: ;
            default: r.legal = 0;
        endcase
        return r;
    endfunction

    function automatic logic [21:0] mk(input logic [2:0] st, input logic imem, input logic dmem,
                                       input logic ir, input logic pc, input ref_t r,
                                       input logic use_alu, input logic use_mem, input logic use_wb,
                                       input logic ill, input logic berr);
        return {st, imem, dmem, ir, pc,
                use_alu ? r.alu_op : 2'b00, use_alu & r.alu_src, use_alu & r.jump, use_alu & r.branch,
                use_wb ? r.mos : 2'b00, use_mem ? r.mr : 3'b000, use_mem ? r.mw : 2'b00,
                use_wb & r.rw, ill, berr};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Scoreboard compare
    task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, o, e, $time);
        end
    endtask

    task automatic drain();
        logic [22:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            mem_ready = e[22];
            #1;
            check(cur_tag, obs, e[21:0]);
        end
    endtask

    task automatic push_trap(input logic ill, input logic berr);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, mk(3'd6, 0, 0, 0, 0, '0, 0, 0, 0, ill, berr)});
        end
    endtask

    // One FETCH or MEM phase: `waits` low-ready cycles then a ready cycle, unless
    // the stall reaches the timeout first.
    task automatic push_phase(input logic [21:0] wait_v, input logic [21:0] ready_v,
                              input int waits, output bit to);
        to = 0;
        for (int i = 0; i < waits; i++) begin
            exp_q.push_back({1'b0, wait_v});
            if (i + 1 == TO) begin
                to = 1;
                return;
            end
        end
        exp_q.push_back({1'b1, ready_v});
    endtask

    // Driver: one instruction from FETCH to its retirement (or trap).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf, input int wm,
                             output bit trapped);
        ref_t r;
        bit   to;
        r       = ref_decode(op, f3);
        opcode  = op;
        funct3  = f3;
        trapped = 0;
        push_phase(mk(3'd1, 1, 0, 0, 0, r, 0, 0, 0, 0, 0), mk(3'd1, 1, 0, 1, 0, r, 0, 0, 0, 0, 0), wf, to);
        if (to) begin
            push_trap(0, 1);
            trapped = 1;
        end else begin
            exp_q.push_back({rnd_bit(), mk(3'd2, 0, 0, 0, 0, r, 0, 0, 0, 0, 0)});
            if (!r.legal) begin
                push_trap(1, 0);
                trapped = 1;
            end else begin
                exp_q.push_back({rnd_bit(), mk(3'd3, 0, 0, 0, r.kind == 2'd3, r, 1, 0, 0, 0, 0)});
                if (r.kind == 2'd1 || r.kind == 2'd2) begin
                    push_phase(mk(3'd4, 0, 1, 0, 0, r, 1, 1, 0, 0, 0),
                               mk(3'd4, 0, 1, 0, r.kind == 2'd2, r, 1, 1, 0, 0, 0), wm, to);
                    if (to) begin
                        push_trap(0, 1);
                        trapped = 1;
                    end
                end
                if (!trapped && (r.kind == 2'd0 || r.kind == 2'd1)) begin
                    exp_q.push_back({rnd_bit(), mk(3'd5, 0, 0, 0, 1, r, 1, 0, 1, 0, 0)});
                end
            end
        end
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = rnd_bit();
        #1;
        check("reset_active", obs, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_idle", obs, '0);
    endtask

    logic [6:0] legal_ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
                                   7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0001111};
    logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        bit   tr;
        ref_t rs;
        logic [6:0] op;
        int   wf, wm;

        #2;
        check("por_async", obs, '0);
        do_reset();

        cur_tag = "add_ready_high";
        run_instr(7'b0110011, 3'd0, 0, 0, tr);
        run_instr(7'b0110011, 3'd0, 0, 0, tr);

        cur_tag = "load_width";
        foreach (load_f3[i]) run_instr(7'b0000011, load_f3[i], 0, 2, tr);
        cur_tag = "store_width";
        for (int f = 0; f < 3; f++) run_instr(7'b0100011, 3'(f), 1, 2, tr);

        cur_tag = "beq";
        run_instr(7'b1100011, 3'd0, 0, 0, tr);
        cur_tag = "jalr";
        run_instr(7'b1100111, 3'd0, 0, 0, tr);
        cur_tag = "misc_ops";
        run_instr(7'b0110111, 3'd0, 0, 0, tr);
        run_instr(7'b0010111, 3'd0, 1, 0, tr);
        run_instr(7'b1101111, 3'd0, 0, 0, tr);
        run_instr(7'b0001111, 3'd0, 0, 0, tr);
        run_instr(7'b0010011, 3'd3, 2, 0, tr);

        cur_tag = "illegal_opcode";
        run_instr(7'b1110011, 3'd0, 0, 0, tr);
        do_reset();
        cur_tag = "illegal_load_f3";
        run_instr(7'b0000011, 3'd3, 0, 0, tr);
        do_reset();

        cur_tag = "fetch_timeout";
        run_instr(7'b0110011, 3'd0, TO, 0, tr);
        check("no_timeout_state", {19'd0, state_z}, 22'd1);
        check("no_timeout_buserr", {21'd0, bus_err_z}, 22'd0);
        do_reset();
        cur_tag = "ready_in_last_wait";
        run_instr(7'b0110011, 3'd0, TO - 1, 0, tr);
        cur_tag = "mem_timeout";
        run_instr(7'b0000011, 3'd2, 0, TO, tr);
        do_reset();

        // Asynchronous reset mid-MEM on a store.
        cur_tag = "mid_store";
        rs = ref_decode(7'b0100011, 3'd2);
        opcode = 7'b0100011;
        funct3 = 3'd2;
        exp_q.push_back({1'b1, mk(3'd1, 1, 0, 1, 0, rs, 0, 0, 0, 0, 0)});
        exp_q.push_back({1'b0, mk(3'd2, 0, 0, 0, 0, rs, 0, 0, 0, 0, 0)});
        exp_q.push_back({1'b0, mk(3'd3, 0, 0, 0, 0, rs, 1, 0, 0, 0, 0)});
        exp_q.push_back({1'b0, mk(3'd4, 0, 1, 0, 0, rs, 1, 1, 0, 0, 0)});
        drain();
        #2 rst = 1'b1;
        #1 check("mid_rst_async", obs, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rst_idle", obs, '0);
        cur_tag = "restart_after_rst";
        run_instr(7'b0110011, 3'd0, 0, 0, tr);

        cur_tag = "random";
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)];
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
            run_instr(op, 3'($urandom_range(0, 7)), wf, wm, tr);
            if (tr) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mc_cu.md
# mc_cu

Multi-cycle control unit for the RV32I core: a state machine sequencing each instruction through fetch, decode, execute, memory and write-back, with a shared memory port handshaked by `mem_ready`. It replaces the single-cycle opcode-only decoder. It decodes `funct3` to select the load and store widths, flags illegal encodings, and can trap on a memory timeout. It sits between the instruction register and the datapath mux, ALU and register-file enables.

## Interface
- `MEM_TIMEOUT`, default 0: number of consecutive `mem_ready`-low cycles in FETCH or MEM before a bus-error trap. A value of 0 disables the timeout.
- `CNT_W`, default 8: width of the wait counter. Requires `MEM_TIMEOUT` < 2^`CNT_W`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `opcode`  in  7  IR[6:0]; sampled in DECODE.
- `funct3`  in  3  IR[14:12]; sampled in DECODE.
- `mem_ready`  in  1  memory accepted or returned data this cycle.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data access request.
- `ir_write`  out  1  load the IR.
- `pc_write`  out  1  update the PC; one pulse per retired instruction.
- `alu_op`  out  2  00 pass-imm, 01 sub/compare, 10 add, 11 use funct.
- `alu_src`  out  1  1 selects the immediate for ALU operand B.
- `branch`, `jump`  out  1 each  PC source. {jump,branch}=10 JAL, 11 JALR, 01 conditional branch.
- `mem_out_sel`  out  2  write-back source: 00 ALU, 01 load data, 10 PC+4, 11 immediate.
- `mem_read`  out  3  001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU, 000 none.
- `mem_write`  out  2  01 SW, 10 SH, 11 SB, 00 none.
- `reg_write`  out  1  register-file write enable.
- `state`  out  3  current state.
- `illegal_instr`, `bus_err`  out  1 each  sticky trap causes.

## Operation
- **State encoding:** IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=6.
- **IDLE:** go to FETCH on the next edge.
- **FETCH:**
  - `imem_req`=1.
  - While `mem_ready`=1: `ir_write`=1 (combinational) and the next state is DECODE.
  - Otherwise stay in FETCH.
- **DECODE:**
  - Register a 13-bit flag word from `opcode`/`funct3`.
  - Next state is EXECUTE, or TRAP with `illegal_instr` set.
- **Decoded flags (alu_op, alu_src, mem_out_sel, reg_write unless stated):**
  - LUI 0110111: 00, 1, 11, 1.
  - AUIPC 0010111: 10, 1, 00, 1.
  - JAL 1101111: 10, 1, 10, 1; jump=1.
  - JALR 1100111: 10, 1, 10, 1; jump=1, branch=1.
  - OP-IMM 0010011: 11, 1, 00, 1.
  - OP 0110011: 11, 0, 00, 1.
  - LOAD 0000011: 10, 1, 01, 1; `mem_read` per `funct3`. `funct3` 011/110/111 is illegal.
  - STORE 0100011: 10, 1, reg_write=0; `mem_write` per `funct3`. `funct3` ≥ 011 is illegal.
  - BRANCH 1100011: 01, 0, branch=1, reg_write=0. `funct3` 010/011 is illegal.
  - FENCE 0001111: all flags 0; treated as a no-op.
  - Any other opcode is illegal.
- **EXECUTE:**
  - BRANCH → FETCH with `pc_write`=1.
  - LOAD/STORE → MEM.
  - Everything else → WB.
- **MEM:**
  - `dmem_req`=1; `mem_read`/`mem_write` are driven.
  - Stay while `mem_ready`=0.
  - When `mem_ready`=1: a store goes to FETCH with `pc_write`=1; a load goes to WB.
- **WB:** `reg_write` from the flag word; `pc_write`=1; next state is FETCH.
- **Output qualification:**
  - `alu_op`, `alu_src`, `branch` and `jump` come from the flag register in EXECUTE, MEM and WB; they are 0 in all other states.
  - `mem_read`/`mem_write` are nonzero only in MEM.
  - `mem_out_sel`/`reg_write` are nonzero only in WB.
- **Wait counter:**
  - Cleared on entry to FETCH/MEM; increments each cycle `mem_ready`=0.
  - If `MEM_TIMEOUT`>0 and `mem_ready` is still low in the `MEM_TIMEOUT`-th waiting cycle, go to TRAP and set `bus_err`.
  - `mem_ready`=1 in that same cycle wins: normal transition, no error.
- **TRAP:** all control outputs 0 and no requests; the block stays in TRAP until reset.

## Timing
- **Reset:** `rst`=1 immediately forces IDLE, with no clock needed. This clears the flag register, counter, `illegal_instr` and `bus_err`, and drives every output to 0 (`state`=0). This holds mid-instruction as well; there is no partial-write recovery.
- **Latency with zero wait (mem_ready high on the first cycle):**
  - Branch: 3 cycles.
  - Store, ALU, LUI, AUIPC, JAL, JALR, FENCE: 4 cycles.
  - Load: 5 cycles.
- **Waits:** each wait cycle in FETCH/MEM adds one cycle.
- **Mealy outputs:** `ir_write`, `pc_write` in MEM, and the state advance depend on `mem_ready` in the same cycle.
- **Pulse widths:** `pc_write` is exactly one cycle per instruction. `ir_write` is exactly one cycle per fetch.
- **Sticky flags:** `illegal_instr`/`bus_err` rise on the edge entering TRAP.

## Test plan
- **ADD with ready held high:** rst released → states 0,1,2,3,5,1. `ir_write` in the first FETCH; `reg_write`=1, `alu_op`=11, `pc_write`=1 in WB; 4 cycles per instruction.
- **Load widths:** LB/LH/LW/LBU/LHU (funct3 000/001/010/100/101), with `mem_ready` low for 2 MEM cycles → `mem_read`=100/010/001/101/011 for 3 MEM cycles; then WB with `mem_out_sel`=01. SB/SH/SW → `mem_write`=11/10/01, and `pc_write` in the ready cycle.
- **Branch and jumps:** BEQ → `pc_write` in EXECUTE with `branch`=1, `alu_op`=01, 3 cycles. JALR → {jump,branch}=11, `mem_out_sel`=10, `reg_write`=1.
- **Illegal encodings:** opcode 1110011, and LOAD with funct3=011 → TRAP (state 6), `illegal_instr`=1, all outputs 0, held for 10 cycles; `rst` clears.
- **Timeout:** `MEM_TIMEOUT`=4 with `mem_ready` stuck low in FETCH → TRAP after the 4th wait cycle, `bus_err`=1. With ready arriving in the 4th cycle → DECODE and no error.
- **Mid-instruction reset:** `rst` asserted asynchronously mid-MEM on a store → `mem_write` drops to 00 before the next edge; restart from IDLE.
